// File: rtl/axi_simple_master.sv
// rtl/axi_simple_master.sv - single-outstanding AXI3 master, one 32-bit single-beat read or write per command
//
// Purpose: turns a valid/ready command handshake into one AXI3 transaction and
// reports completion with read data, response code, ID check and latency.
//
// Ports:
//   clk, rstn            clock (posedge) and asynchronous active-low reset
//   i_valid / o_ready    command handshake; o_ready is high only while idle
//   i_write              1 = write, 0 = read
//   i_addr               byte address, bits [1:0] driven as 0 on the bus
//   i_wdata, i_wstrb     write data and byte strobes
//   o_done               one-cycle completion pulse
//   o_rdata              read data, held until the next read completes
//   o_resp               BRESP/RRESP of the last transaction
//   o_idmis              last response ID differed from TXN_ID
//   o_lat                accept-to-done cycle count, saturating, held between commands
//   m_aw*, m_w*, m_b*, m_ar*, m_r*   AXI3 master channels (single beat, fixed ID)

module axi_simple_master #(
    parameter int IWIDTH = 12,
    parameter int TXN_ID = 0,
    parameter int LAT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_write,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic [1:0]        o_resp,
    output logic              o_idmis,
    output logic [LAT_W-1:0]  o_lat,
    output logic [IWIDTH-1:0] m_awid,
    output logic [31:0]       m_awaddr,
    output logic [3:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic [1:0]        m_awlock,
    output logic [3:0]        m_awcache,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [IWIDTH-1:0] m_wid,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [IWIDTH-1:0] m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [IWIDTH-1:0] m_arid,
    output logic [31:0]       m_araddr,
    output logic [3:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [1:0]        m_arlock,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [IWIDTH-1:0] m_rid,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam logic [IWIDTH-1:0] TXN     = IWIDTH'(TXN_ID);
    localparam logic [LAT_W-1:0]  LAT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_pend, w_pend;
    logic [LAT_W-1:0]  lat_q, lat_inc;
    logic              accept, b_evt, r_evt;

    // RLAST is meaningless for single-beat reads; address LSBs are never driven.
    logic unused_inputs;
    assign unused_inputs = ^{m_rlast, i_addr[1:0]};

    assign accept  = i_valid && o_ready;
    assign lat_inc = (lat_q == LAT_MAX) ? lat_q : lat_q + LAT_W'(1);

    // Constant bus fields: one 4-byte INCR beat with this master's ID.
    assign m_awid    = TXN;
    assign m_awaddr  = addr_q;
    assign m_awlen   = 4'd0;
    assign m_awsize  = 3'b010;
    assign m_awburst = 2'b01;
    assign m_awlock  = 2'b00;
    assign m_awcache = 4'd0;
    assign m_awprot  = 3'd0;
    assign m_wid     = TXN;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wlast   = 1'b1;
    assign m_arid    = TXN;
    assign m_araddr  = addr_q;
    assign m_arlen   = 4'd0;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'd0;
    assign m_arprot  = 3'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            lat_q   <= '0;
            o_done  <= 1'b0;
            o_rdata <= '0;
            o_resp  <= '0;
            o_idmis <= 1'b0;
            o_lat   <= '0;
        end else begin
            state  <= state_nxt;
            o_done <= b_evt || r_evt;
            if (accept) begin
                addr_q  <= {i_addr[31:2], 2'b00};
                wdata_q <= i_wdata;
                wstrb_q <= i_wstrb;
                aw_pend <= i_write;
                w_pend  <= i_write;
                lat_q   <= LAT_W'(1);
            end else begin
                if (state != IDLE) begin
                    lat_q <= lat_inc;
                end
                // Each write channel retires independently; its VALID falls next cycle.
                if (m_awvalid && m_awready) begin
                    aw_pend <= 1'b0;
                end
                if (m_wvalid && m_wready) begin
                    w_pend <= 1'b0;
                end
            end
            // lat_inc accounts for the cycle in which o_done becomes visible.
            if (b_evt) begin
                o_resp  <= m_bresp;
                o_idmis <= (m_bid != TXN);
                o_lat   <= lat_inc;
            end
            if (r_evt) begin
                o_rdata <= m_rdata;
                o_resp  <= m_rresp;
                o_idmis <= (m_rid != TXN);
                o_lat   <= lat_inc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        b_evt     = 1'b0;
        r_evt     = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_nxt = i_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                m_awvalid = aw_pend;
                m_wvalid  = w_pend;
                if ((!aw_pend || m_awready) && (!w_pend || m_wready)) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    b_evt     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    r_evt     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_simple_master.sv
// tb/tb_axi_simple_master.sv - table-driven bench for axi_simple_master with a behavioural AXI slave
module tb_axi_simple_master;

    localparam int IW     = 12;
    localparam int TXN_ID = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        i_valid = 0, i_write = 0;
    logic [31:0] i_addr = 0, i_wdata = 0;
    logic [3:0]  i_wstrb = 0;

    // slave-driven inputs
    logic          s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0, s_rlast = 0;
    logic [IW-1:0] s_bid = 0, s_rid = 0;
    logic [1:0]    s_bresp = 0, s_rresp = 0;
    logic [31:0]   s_rdata = 0;

    // main DUT outputs
    logic          o_ready, o_done, o_idmis;
    logic [31:0]   o_rdata;
    logic [1:0]    o_resp;
    logic [15:0]   o_lat;
    logic [IW-1:0] m_awid, m_wid, m_arid;
    logic [31:0]   m_awaddr, m_wdata, m_araddr;
    logic [3:0]    m_awlen, m_awcache, m_wstrb, m_arlen, m_arcache;
    logic [2:0]    m_awsize, m_awprot, m_arsize, m_arprot;
    logic [1:0]    m_awburst, m_awlock, m_arburst, m_arlock;
    logic          m_awvalid, m_wlast, m_wvalid, m_bready, m_arvalid, m_rready;

    // 4-bit latency twin: same commands and slave signals, so it runs in lockstep
    logic          d_ready, d_done, d_idmis;
    logic [31:0]   d_rdata;
    logic [1:0]    d_resp;
    logic [3:0]    d_lat;
    logic [IW-1:0] d_awid, d_wid, d_arid;
    logic [31:0]   d_awaddr, d_wdata, d_araddr;
    logic [3:0]    d_awlen, d_awcache, d_wstrb, d_arlen, d_arcache;
    logic [2:0]    d_awsize, d_awprot, d_arsize, d_arprot;
    logic [1:0]    d_awburst, d_awlock, d_arburst, d_arlock;
    logic          d_awvalid, d_wlast, d_wvalid, d_bready, d_arvalid, d_rready;

    axi_simple_master #(.IWIDTH(IW), .TXN_ID(TXN_ID), .LAT_W(16)) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_write(i_write),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_done(o_done), .o_rdata(o_rdata),
        .o_resp(o_resp), .o_idmis(o_idmis), .o_lat(o_lat),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(s_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(s_wready),
        .m_bid(s_bid), .m_bresp(s_bresp), .m_bvalid(s_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(s_arready),
        .m_rid(s_rid), .m_rdata(s_rdata), .m_rresp(s_rresp), .m_rlast(s_rlast),
        .m_rvalid(s_rvalid), .m_rready(m_rready)
    );

    axi_simple_master #(.IWIDTH(IW), .TXN_ID(TXN_ID), .LAT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(d_ready), .i_write(i_write),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_done(d_done), .o_rdata(d_rdata),
        .o_resp(d_resp), .o_idmis(d_idmis), .o_lat(d_lat),
        .m_awid(d_awid), .m_awaddr(d_awaddr), .m_awlen(d_awlen), .m_awsize(d_awsize),
        .m_awburst(d_awburst), .m_awlock(d_awlock), .m_awcache(d_awcache), .m_awprot(d_awprot),
        .m_awvalid(d_awvalid), .m_awready(s_awready),
        .m_wid(d_wid), .m_wdata(d_wdata), .m_wstrb(d_wstrb), .m_wlast(d_wlast),
        .m_wvalid(d_wvalid), .m_wready(s_wready),
        .m_bid(s_bid), .m_bresp(s_bresp), .m_bvalid(s_bvalid), .m_bready(d_bready),
        .m_arid(d_arid), .m_araddr(d_araddr), .m_arlen(d_arlen), .m_arsize(d_arsize),
        .m_arburst(d_arburst), .m_arlock(d_arlock), .m_arcache(d_arcache), .m_arprot(d_arprot),
        .m_arvalid(d_arvalid), .m_arready(s_arready),
        .m_rid(s_rid), .m_rdata(s_rdata), .m_rresp(s_rresp), .m_rlast(s_rlast),
        .m_rvalid(s_rvalid), .m_rready(d_rready)
    );

    // ---------------- behavioural slave (evaluated on negedge) ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, rid_off = 0;
    logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
    logic [31:0] mem [4];
    logic [31:0] got_awaddr = 0, got_araddr = 0, got_wdata = 0, aw_first = 0, ar_first = 0, w_first = 0;
    logic [3:0]  got_wstrb = 0;
    bit          aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    int          aw_hi = 0, w_hi = 0, stab_err = 0, fix_err = 0, done_cnt = 0;

    always @(negedge clk) if (o_done) done_cnt++;

    always @(negedge clk) begin
        if (!rstn) begin
            s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        end else begin
            if (b_fire) begin s_bvalid = 0; b_fire = 0; end
            if (!s_bvalid && aw_got && w_got) begin
                for (int b = 0; b < 4; b++)
                    if (got_wstrb[b]) mem[got_awaddr[3:2]][8*b +: 8] = got_wdata[8*b +: 8];
                s_bvalid = 1; s_bresp = bresp_cfg; s_bid = IW'(TXN_ID + rid_off);
                aw_got = 0; w_got = 0;
            end
            if (s_bvalid && m_bready) b_fire = 1;

            if (r_fire) begin s_rvalid = 0; r_fire = 0; end
            if (!s_rvalid && ar_got) begin
                // register 3 of the model reads back register 2
                s_rdata = (got_araddr[3:2] == 2'd3) ? mem[2] : mem[got_araddr[3:2]];
                s_rvalid = 1; s_rresp = rresp_cfg; s_rid = IW'(TXN_ID + rid_off); s_rlast = 1;
                ar_got = 0;
            end
            if (s_rvalid && m_rready) r_fire = 1;

            if (m_awvalid) begin
                aw_hi++;
                if (aw_cnt == 0) aw_first = m_awaddr; else if (m_awaddr !== aw_first) stab_err++;
                if (m_awlen !== 4'd0 || m_awsize !== 3'b010 || m_awburst !== 2'b01 || m_awlock !== 2'b00 ||
                    m_awcache !== 4'd0 || m_awprot !== 3'd0 || m_awid !== IW'(TXN_ID)) fix_err++;
                s_awready = (aw_cnt >= aw_delay);
                if (s_awready) begin aw_got = 1; got_awaddr = m_awaddr; end
                aw_cnt++;
            end else begin s_awready = 0; aw_cnt = 0; end

            if (m_wvalid) begin
                w_hi++;
                if (w_cnt == 0) w_first = m_wdata; else if (m_wdata !== w_first) stab_err++;
                if (m_wlast !== 1'b1 || m_wid !== IW'(TXN_ID)) fix_err++;
                s_wready = (w_cnt >= w_delay);
                if (s_wready) begin w_got = 1; got_wdata = m_wdata; got_wstrb = m_wstrb; end
                w_cnt++;
            end else begin s_wready = 0; w_cnt = 0; end

            if (m_arvalid) begin
                if (ar_cnt == 0) ar_first = m_araddr; else if (m_araddr !== ar_first) stab_err++;
                if (m_arlen !== 4'd0 || m_arsize !== 3'b010 || m_arburst !== 2'b01 || m_arlock !== 2'b00 ||
                    m_arcache !== 4'd0 || m_arprot !== 3'd0 || m_arid !== IW'(TXN_ID)) fix_err++;
                s_arready = (ar_cnt >= ar_delay);
                if (s_arready) begin ar_got = 1; got_araddr = m_araddr; end
                ar_cnt++;
            end else begin s_arready = 0; ar_cnt = 0; end
        end
    end

    // ---------------- checking ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        int          awd, wd, ard;
        logic [1:0]  bresp, rresp;
        int          rid_off;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_idmis;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int awd, input int wd, input int ard,
                                input logic [1:0] bresp, input logic [1:0] rresp, input int roff,
                                input logic [31:0] erd, input logic [1:0] eresp, input logic eid, input int elat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.awd = awd; v.wd = wd; v.ard = ard;
        v.bresp = bresp; v.rresp = rresp; v.rid_off = roff;
        v.exp_rdata = erd; v.exp_resp = eresp; v.exp_idmis = eid; v.exp_lat = elat;
        return v;
    endfunction

    int aw0, w0;

    task automatic run_vec(input vec_t v, input string nm);
        int cyc, st0, fx0, dn0, e4;
        bit done;
        logic [31:0] ea;
        aw_delay = v.awd; w_delay = v.wd; ar_delay = v.ard;
        bresp_cfg = v.bresp; rresp_cfg = v.rresp; rid_off = v.rid_off;
        ea = {v.addr[31:2], 2'b00};
        @(negedge clk);
        chk({nm, "_ready"}, o_ready, 1);
        aw0 = aw_hi; w0 = w_hi; st0 = stab_err; fx0 = fix_err; dn0 = done_cnt;
        i_valid = 1; i_write = v.wr; i_addr = v.addr; i_wdata = v.wdata; i_wstrb = v.wstrb;
        cyc = 0; done = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            // scramble the command inputs after accept; they must not matter
            i_valid = 0; i_write = ~v.wr; i_addr = ~v.addr; i_wdata = ~v.wdata; i_wstrb = ~v.wstrb;
            cyc++;
            if (o_done) done = 1;
        end
        e4 = (v.exp_lat > 15) ? 15 : v.exp_lat;
        chk({nm, "_done"}, done, 1);
        chk({nm, "_cycles"}, cyc, v.exp_lat);
        chk({nm, "_lat"}, o_lat, v.exp_lat);
        chk({nm, "_lat4"}, d_lat, e4);
        chk({nm, "_resp"}, o_resp, v.exp_resp);
        chk({nm, "_idmis"}, o_idmis, v.exp_idmis);
        if (!v.wr) chk({nm, "_rdata"}, o_rdata, v.exp_rdata);
        chk({nm, "_busaddr"}, v.wr ? got_awaddr : got_araddr, ea);
        if (v.wr) chk({nm, "_wdata"}, {got_wstrb, got_wdata}, {v.wstrb, v.wdata});
        chk({nm, "_stable"}, stab_err - st0, 0);
        chk({nm, "_fixed"}, fix_err - fx0, 0);
        @(negedge clk);
        chk({nm, "_pulse"}, o_done, 0);
        chk({nm, "_donecnt"}, done_cnt - dn0, 1);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = mk(1, 32'h8, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 0, 0,            0, 0, 3);
        vecs[1] = mk(0, 32'hC, 0,            0,    0, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 3);
        vecs[2] = mk(1, 32'h0, 32'hAABBCCDD, 4'h5, 0, 0, 0, 0, 0, 0, 0,            0, 0, 3);
        vecs[3] = mk(0, 32'h3, 0,            0,    0, 0, 0, 0, 0, 0, 32'h00BB00DD, 0, 0, 3);
        vecs[4] = mk(1, 32'h4, 32'hCAFEF00D, 4'hF, 0, 2, 0, 1, 0, 0, 0,            1, 0, 5);
        vecs[5] = mk(0, 32'h4, 0,            0,    0, 0, 3, 0, 2, 1, 32'hCAFEF00D, 2, 1, 6);
        vecs[6] = mk(0, 32'h8, 0,            0,    0, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 3);
        vecs[7] = mk(1, 32'h4, 32'h00000099, 4'h1, 2, 4, 0, 0, 0, 2, 0,            0, 1, 7);
        vecs[8] = mk(0, 32'h4, 0,            0,    0, 0, 0, 0, 0, 0, 32'hCAFEF099, 0, 0, 3);

        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        chk("rst_outs", {o_done, o_rdata, o_resp, o_idmis, o_lat}, 0);
        rstn = 1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) chk("vec0_reg2", mem[2], 32'h12345678);
        end
        chk("reg1_merged", mem[1], 32'hCAFEF099);

        // AW held off 5 cycles while W is taken at once
        run_vec(mk(1, 32'h0, 32'h11223344, 4'hF, 5, 0, 0, 0, 0, 0, 0, 0, 0, 8), "awstall");
        chk("awstall_whigh", w_hi - w0, 1);
        chk("awstall_awhigh", aw_hi - aw0, 6);
        chk("awstall_reg0", mem[0], 32'h11223344);

        // long AR stall: 16-bit counter shows 23, 4-bit twin saturates at 15
        run_vec(mk(0, 32'h8, 0, 0, 0, 0, 20, 0, 0, 0, 32'h12345678, 0, 0, 23), "arsat");

        // reset while both AW and W are still waiting
        aw_delay = 10; w_delay = 10;
        @(negedge clk);
        i_valid = 1; i_write = 1; i_addr = 32'h8; i_wdata = 32'h55; i_wstrb = 4'hF;
        @(negedge clk);
        i_valid = 0;
        @(negedge clk);
        chk("pre_rst_valids", {m_awvalid, m_wvalid}, 2'b11);
        #2 rstn = 0;
        #1;
        chk("async_rst_valids", {m_awvalid, m_wvalid}, 0);
        chk("async_rst_ready", o_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
        chk("post_rst_ready", o_ready, 1);
        chk("post_rst_outs", {o_done, o_rdata, o_resp, o_idmis, o_lat}, 0);
        run_vec(mk(1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3), "post_rst_wr");
        run_vec(mk(0, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 3), "post_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
